// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer bus: the request/ack/clear inputs and the per-channel reset
// and status outputs. master = sequencer, slave = the block that consumes it.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_CH = 4
) ();
  localparam int unsigned CH_W = $clog2(NUM_CH) + 1;

  logic              rst_req_n;
  logic [NUM_CH-1:0] ch_ack;
  logic              err_clr;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              seq_done;
  logic              busy;
  logic [CH_W-1:0]   cur_ch;
  logic [NUM_CH-1:0] timeout_err;

  modport master (
    input  rst_req_n, ch_ack, err_clr,
    output ch_rst_n, seq_done, busy, cur_ch, timeout_err
  );

  modport slave (
    output rst_req_n, ch_ack, err_clr,
    input  ch_rst_n, seq_done, busy, cur_ch, timeout_err
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// N-channel reset sequencer: holds every channel in reset, then releases them
// one at a time in index order, optionally waiting (with timeout) for an ack.
module rst_seq_ctrl #(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       CNT_W       = 16,
  parameter int unsigned       MIN_ASSERT  = 16,
  parameter int unsigned       RELEASE_GAP = 8,
  parameter int unsigned       TIMEOUT     = 1024,
  parameter logic [NUM_CH-1:0] ACK_EN      = '0
) (
  input  logic           clk,
  input  logic           reset,
  rst_seq_ctrl_if.master bus
);

  localparam int unsigned CH_W = $clog2(NUM_CH) + 1;

  localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_ASSERT);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (RELEASE_GAP == 0) ? '0 : CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NUM_CH-1:0] ch_rst_n_r, ch_rst_n_nxt;
  logic [CH_W-1:0]   cur_ch_r, cur_ch_nxt;
  logic              seq_done_r, seq_done_nxt;
  logic              busy_r;
  logic [NUM_CH-1:0] timeout_err_r, timeout_err_nxt;

  logic [NUM_CH-1:0] cur_mask;
  logic [NUM_CH-1:0] err_set;
  logic              ack_ok;
  logic              timed_out;
  logic              advance;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ch_rst_n_nxt = ch_rst_n_r;
    cur_ch_nxt   = cur_ch_r;
    seq_done_nxt = seq_done_r;
    err_set      = '0;
    advance      = 1'b0;

    cur_mask  = ch_onehot(cur_ch_r);
    // A channel without ACK_EN counts as acked; an ack already high on entry counts too.
    ack_ok    = ((ACK_EN & cur_mask) == '0) || ((bus.ch_ack & cur_mask) != '0);
    timed_out = (TIMEOUT != 0) && (cnt == TO_LAST) && !ack_ok;

    if (!bus.rst_req_n) begin
      state_nxt    = ST_ASSERT;
      cnt_nxt      = '0;
      ch_rst_n_nxt = '0;
      cur_ch_nxt   = '0;
      seq_done_nxt = 1'b0;
    end else begin
      unique case (state)
        ST_ASSERT: begin
          ch_rst_n_nxt = '0;
          if (cnt >= MIN_LAST) begin
            state_nxt    = ST_WAIT_ACK;
            cnt_nxt      = '0;
            cur_ch_nxt   = '0;
            ch_rst_n_nxt = NUM_CH'(1);
          end else begin
            cnt_nxt = sat_inc(cnt, MIN_LIM);
          end
        end
        ST_WAIT_ACK: begin
          if (ack_ok || timed_out) begin
            cnt_nxt = '0;
            if (timed_out) err_set = cur_mask;
            // With no gap configured the next channel is released straight from here.
            if (RELEASE_GAP == 0) advance = 1'b1;
            else                  state_nxt = ST_GAP;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt >= GAP_LAST) advance = 1'b1;
          else                 cnt_nxt = cnt + CNT_W'(1);
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_ASSERT;
      endcase

      if (advance) begin
        cnt_nxt = '0;
        if (cur_ch_r >= LAST_CH) begin
          seq_done_nxt = 1'b1;
          state_nxt    = ST_DONE;
        end else begin
          cur_ch_nxt   = cur_ch_r + CH_W'(1);
          ch_rst_n_nxt = ch_rst_n_r | (cur_mask << 1);
          state_nxt    = ST_WAIT_ACK;
        end
      end
    end

    // A new timeout beats a simultaneous clear on its own bit only.
    timeout_err_nxt = err_set | (bus.err_clr ? '0 : timeout_err_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_ASSERT;
      cnt           <= '0;
      ch_rst_n_r    <= '0;
      cur_ch_r      <= '0;
      seq_done_r    <= 1'b0;
      busy_r        <= 1'b1;
      timeout_err_r <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      ch_rst_n_r    <= ch_rst_n_nxt;
      cur_ch_r      <= cur_ch_nxt;
      seq_done_r    <= seq_done_nxt;
      busy_r        <= (state_nxt != ST_DONE);
      timeout_err_r <= timeout_err_nxt;
    end
  end

  assign bus.ch_rst_n    = ch_rst_n_r;
  assign bus.seq_done    = seq_done_r;
  assign bus.busy        = busy_r;
  assign bus.cur_ch      = cur_ch_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: one instance without ack waits, one with
// acks enabled on channels 1 and 3; edge numbers count from reset release.
module tb_rst_seq_ctrl;
  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned MIN_ASSERT  = 16;
  localparam int unsigned RELEASE_GAP = 8;
  localparam int unsigned TIMEOUT     = 32;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_CH(NUM_CH)) bus_a ();
  rst_seq_ctrl_if #(.NUM_CH(NUM_CH)) bus_b ();

  rst_seq_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_ASSERT(MIN_ASSERT),
    .RELEASE_GAP(RELEASE_GAP), .TIMEOUT(TIMEOUT), .ACK_EN(4'b0000)
  ) u_dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.master)
  );

  rst_seq_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_ASSERT(MIN_ASSERT),
    .RELEASE_GAP(RELEASE_GAP), .TIMEOUT(TIMEOUT), .ACK_EN(4'b1010)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.master)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int ecnt   = 0;
  int rise[4];
  int err_e[4];
  int done_e;
  int busyf_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_rec();
    for (int c = 0; c < 4; c++) begin
      rise[c]  = -1;
      err_e[c] = -1;
    end
    done_e  = -1;
    busyf_e = -1;
  endtask

  // Advance to edge n, noting the first edge each output was seen set.
  task automatic run_to(input bit sel, input int n);
    logic [3:0] r, e;
    logic       d, b;
    while (ecnt < n) begin
      tick();
      ecnt++;
      r = sel ? bus_b.ch_rst_n    : bus_a.ch_rst_n;
      e = sel ? bus_b.timeout_err : bus_a.timeout_err;
      d = sel ? bus_b.seq_done    : bus_a.seq_done;
      b = sel ? bus_b.busy        : bus_a.busy;
      for (int c = 0; c < 4; c++) begin
        if (rise[c] < 0 && r[c]) rise[c] = ecnt;
        if (err_e[c] < 0 && e[c]) err_e[c] = ecnt;
      end
      if (done_e < 0 && d) done_e = ecnt;
      if (busyf_e < 0 && !b) busyf_e = ecnt;
    end
  endtask

  task automatic start(input bit sel);
    if (sel) reset_b = 1'b1; else reset_a = 1'b1;
    tick();
    tick();
    if (sel) reset_b = 1'b0; else reset_a = 1'b0;
    ecnt = 0;
    clr_rec();
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.rst_req_n = 1'b1;
    bus_a.ch_ack    = '0;
    bus_a.err_clr   = 1'b0;
    bus_b.rst_req_n = 1'b1;
    bus_b.ch_ack    = '0;
    bus_b.err_clr   = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_ch_rst_n", bus_a.ch_rst_n, 4'b0000);
    chk("rst_seq_done", bus_a.seq_done, 1'b0);
    chk("rst_busy", bus_a.busy, 1'b1);
    chk("rst_cur_ch", bus_a.cur_ch, 3'd0);
    chk("rst_timeout_err", bus_a.timeout_err, 4'b0000);

    // 1: no acks, release spacing RELEASE_GAP+1
    reset_a = 1'b0;
    ecnt = 0;
    clr_rec();
    run_to(0, 60);
    chk("t1_rise0", rise[0], 16);
    chk("t1_rise1", rise[1], 25);
    chk("t1_rise2", rise[2], 34);
    chk("t1_rise3", rise[3], 43);
    chk("t1_done", done_e, 52);
    chk("t1_busy_fall", busyf_e, 52);
    chk("t1_cur_ch", bus_a.cur_ch, 3'd3);
    // abort out of DONE
    bus_a.rst_req_n = 1'b0;
    tick();
    bus_a.rst_req_n = 1'b1;
    chk("t1_abort_done", bus_a.seq_done, 1'b0);
    chk("t1_abort_busy", bus_a.busy, 1'b1);
    chk("t1_abort_rst_n", bus_a.ch_rst_n, 4'b0000);

    // 4: one-cycle abort while channel 2 is being sequenced
    start(0);
    run_to(0, 34);
    chk("t4_cur_ch_pre", bus_a.cur_ch, 3'd2);
    chk("t4_rst_n_pre", bus_a.ch_rst_n, 4'b0111);
    bus_a.rst_req_n = 1'b0;
    run_to(0, 35);
    bus_a.rst_req_n = 1'b1;
    chk("t4_rst_n_abort", bus_a.ch_rst_n, 4'b0000);
    chk("t4_seq_done", bus_a.seq_done, 1'b0);
    chk("t4_cur_ch", bus_a.cur_ch, 3'd0);
    clr_rec();
    run_to(0, 60);
    chk("t4_rerise0", rise[0], 51);
    chk("t4_rerise1", rise[1], 60);

    // 5: async reset mid-gap, no clock edge in between
    start(0);
    run_to(0, 20);
    chk("t5_rst_n_pre", bus_a.ch_rst_n, 4'b0001);
    #2 reset_a = 1'b1;
    #1;
    chk("t5_rst_n_async", bus_a.ch_rst_n, 4'b0000);
    chk("t5_busy_async", bus_a.busy, 1'b1);
    tick();
    reset_a = 1'b0;

    // 2: ack on channel 1 arrives 10 cycles after its release
    start(1);
    run_to(1, 35);
    chk("t2_rise0", rise[0], 16);
    chk("t2_rise1", rise[1], 25);
    bus_b.ch_ack = 4'b1010;
    run_to(1, 70);
    chk("t2_rise2", rise[2], 44);
    chk("t2_rise3", rise[3], 53);
    chk("t2_done", done_e, 62);
    chk("t2_timeout_err", bus_b.timeout_err, 4'b0000);

    // 3: channel 1 never acks, times out, sequence still completes
    bus_b.ch_ack = 4'b1000;
    start(1);
    run_to(1, 90);
    chk("t3_err1_edge", err_e[1], 57);
    chk("t3_rise2", rise[2], 65);
    chk("t3_rise3", rise[3], 74);
    chk("t3_done", done_e, 83);
    chk("t3_timeout_err", bus_b.timeout_err, 4'b0010);
    chk("t3_rise1_kept", bus_b.ch_rst_n, 4'b1111);
    bus_b.err_clr = 1'b1;
    tick();
    bus_b.err_clr = 1'b0;
    chk("t3_err_clr", bus_b.timeout_err, 4'b0000);

    // 6: clear lands in the same cycle as the channel 3 timeout
    bus_b.ch_ack = 4'b0000;
    start(1);
    run_to(1, 105);
    chk("t6_err_pre", bus_b.timeout_err, 4'b0010);
    bus_b.err_clr = 1'b1;
    run_to(1, 106);
    bus_b.err_clr = 1'b0;
    chk("t6_err_set_wins", bus_b.timeout_err, 4'b1000);
    run_to(1, 120);
    chk("t6_done", done_e, 114);
    chk("t6_seq_done", bus_b.seq_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
